// File: rtl/matmul_result_drain_pkg.sv
// Shared constants and types for the systolic multiplier result drain.
// Optional normalization output is enabled with MATMUL_DRAIN_NORM_EN.
package matmul_pkg;

  localparam int N     = 5;
  localparam int ACC_W = 2 * N + 4;
  localparam int DIM   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } state_e;

  typedef logic [ACC_W-1:0] result_t;

endpackage

// File: rtl/matmul_result_drain_if.sv
// Result stream from the drain to the downstream consumer (valid/ready).
// Carries o_norm/o_exp only when MATMUL_DRAIN_NORM_EN is defined.
interface matmul_result_drain_if;
  import matmul_pkg::*;

  result_t o_data;
  logic    o_valid;
  logic    o_ready;
  logic    o_last;

`ifdef MATMUL_DRAIN_NORM_EN
  logic [N-2:0] o_norm;
  logic [3:0]   o_exp;

  modport master (output o_data, o_valid, o_last, o_norm, o_exp, input o_ready);
  modport slave  (input o_data, o_valid, o_last, o_norm, o_exp, output o_ready);
`else
  modport master (output o_data, o_valid, o_last, input o_ready);
  modport slave  (input o_data, o_valid, o_last, output o_ready);
`endif

endinterface

// File: rtl/matmul_result_drain_lead_one_norm.sv
// Combinational leading-one window extractor: picks a W-bit window under the
// highest set bit of v, saturating when the top two bits are in use.
module lead_one_norm #(
  parameter int ACC_W = 14,
  parameter int W     = 4
) (
  input  logic [ACC_W-1:0] v,
  output logic [W-1:0]     norm,
  output logic [3:0]       exp_o
);

  always_comb begin
    norm  = v[W-1:0];
    exp_o = '0;
    // Ascending scan so the highest set bit is the one that sticks.
    for (int j = W; j <= ACC_W - 3; j++) begin
      if (v[j]) begin
        norm  = W'(v >> (j - W + 1));
        exp_o = 4'(j - W + 1);
      end
    end
    if (|v[ACC_W-1:ACC_W-2]) begin
      norm  = '1;
      exp_o = 4'(ACC_W - 2 - W);
    end
  end

endmodule

// File: rtl/matmul_result_drain.sv
// De-skews the three column streams of the 3x3 systolic array into a register
// file and replays them row-major over valid/ready. Option: MATMUL_DRAIN_NORM_EN.
module matmul_result_drain
  import matmul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  result_t              c_in0,
  input  result_t              c_in1,
  input  result_t              c_in2,
  input  logic [DIM-1:0]       c_vld,
  output logic                 in_ready,
  output logic                 err,
  matmul_result_drain_if.master dout
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_SEND    = SEND;
  localparam int         CELLS     = DIM * DIM;
  localparam logic [3:0] LAST_IDX  = 4'(CELLS - 1);

  result_t        c_in_arr [DIM];
  logic [1:0]     state_reg;
  logic [1:0]     rc_reg   [DIM];
  logic [1:0]     rc_next  [DIM];
  logic [3:0]     wr_addr  [DIM];
  logic [DIM-1:0] cap;
  logic [DIM-1:0] drop;
  logic [DIM-1:0] full_next;
  result_t        mem_reg  [CELLS];
  logic [3:0]     idx_reg;
  logic [3:0]     idx_inc;
  logic           accepting;
  logic           fill_done;
  logic           hs;
  logic           last_hs;
  logic           load_en;
  result_t        data_load;
  result_t        o_data_reg;
  logic           o_valid_reg;
  logic           o_last_reg;
  logic           in_ready_reg;
  logic           err_reg;

  assign c_in_arr[0] = c_in0;
  assign c_in_arr[1] = c_in1;
  assign c_in_arr[2] = c_in2;

  assign accepting = (state_reg != S_SEND);

  // Each column fills its own rows independently; anything not captured is a drop.
  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_col
      assign cap[gi]       = accepting && c_vld[gi] && (rc_reg[gi] != 2'd3);
      assign drop[gi]      = c_vld[gi] && !cap[gi];
      assign rc_next[gi]   = rc_reg[gi] + {1'b0, cap[gi]};
      assign full_next[gi] = (rc_next[gi] == 2'd3);
      assign wr_addr[gi]   = 4'(rc_reg[gi]) * 4'd3 + 4'(gi);
    end
  endgenerate

  assign fill_done = accepting && (&full_next);
  assign hs        = o_valid_reg && dout.o_ready;
  assign last_hs   = hs && (idx_reg == LAST_IDX);
  assign idx_inc   = (idx_reg == LAST_IDX) ? 4'd0 : idx_reg + 4'd1;
  // Row 0 of every column is always written before the completing capture,
  // so mem_reg[0] is already valid on the fill_done cycle.
  assign load_en   = fill_done || (hs && !last_hs);
  assign data_load = fill_done ? mem_reg[0] : mem_reg[idx_inc];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      o_data_reg   <= '0;
      o_valid_reg  <= 1'b0;
      o_last_reg   <= 1'b0;
      in_ready_reg <= 1'b1;
      err_reg      <= 1'b0;
      for (int k = 0; k < DIM; k++) rc_reg[k] <= '0;
      for (int m = 0; m < CELLS; m++) mem_reg[m] <= '0;
    end else begin
      err_reg <= err_reg | (|drop);
      for (int k = 0; k < DIM; k++) begin
        if (cap[k]) mem_reg[wr_addr[k]] <= c_in_arr[k];
      end
      if (load_en) o_data_reg <= data_load;

      case (state_reg)
        S_IDLE, S_COLLECT: begin
          for (int k = 0; k < DIM; k++) rc_reg[k] <= rc_next[k];
          if (fill_done) begin
            state_reg    <= S_SEND;
            o_valid_reg  <= 1'b1;
            o_last_reg   <= 1'b0;
            in_ready_reg <= 1'b0;
            idx_reg      <= '0;
          end else if (|c_vld) begin
            state_reg <= S_COLLECT;
          end
        end
        S_SEND: begin
          if (last_hs) begin
            state_reg    <= S_IDLE;
            o_valid_reg  <= 1'b0;
            o_last_reg   <= 1'b0;
            in_ready_reg <= 1'b1;
            idx_reg      <= '0;
            for (int k = 0; k < DIM; k++) rc_reg[k] <= '0;
          end else if (hs) begin
            idx_reg    <= idx_inc;
            o_last_reg <= (idx_inc == LAST_IDX);
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign dout.o_data  = o_data_reg;
  assign dout.o_valid = o_valid_reg;
  assign dout.o_last  = o_last_reg;
  assign in_ready     = in_ready_reg;
  assign err          = err_reg;

`ifdef MATMUL_DRAIN_NORM_EN
  logic [N-2:0] norm_w;
  logic [N-2:0] o_norm_reg;
  logic [3:0]   exp_w;
  logic [3:0]   o_exp_reg;

  lead_one_norm #(
    .ACC_W (ACC_W),
    .W     (N - 1)
  ) u_norm (
    .v     (data_load),
    .norm  (norm_w),
    .exp_o (exp_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      o_norm_reg <= '0;
      o_exp_reg  <= '0;
    end else if (load_en) begin
      o_norm_reg <= norm_w;
      o_exp_reg  <= exp_w;
    end
  end

  assign dout.o_norm = o_norm_reg;
  assign dout.o_exp  = o_exp_reg;
`endif

endmodule

// File: tb/tb_matmul_result_drain.sv
// Scoreboard bench for matmul_result_drain: stimulus pushes expected results,
// a negedge monitor pops and compares on every handshake.
module tb_matmul_result_drain;
  import matmul_pkg::*;

  typedef struct {
    result_t    d;
    bit         last;
    bit         chk_norm;
    logic [3:0] norm;
    logic [3:0] ex;
  } exp_t;

  logic           clk;
  logic           rst;
  result_t        c_in0, c_in1, c_in2;
  logic [DIM-1:0] c_vld;
  logic           in_ready;
  logic           err;

  matmul_result_drain_if bus ();

  matmul_result_drain dut (
    .clk      (clk),
    .rst      (rst),
    .c_in0    (c_in0),
    .c_in1    (c_in1),
    .c_in2    (c_in2),
    .c_vld    (c_vld),
    .in_ready (in_ready),
    .err      (err),
    .dout     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      total = 0;
  int      bad   = 0;
  int      hs_cnt = 0;
  exp_t    sbq[$];
  bit      bp_mode = 0;
  int      bp_ph = 0;
  bit      stall_pend = 0;
  result_t held_d;
  result_t vals[9];

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_mode) begin
      bus.o_ready = (bp_ph % 3 == 0);
      bp_ph++;
    end
  endtask

  task automatic drive(input logic [2:0] v, input result_t a, input result_t b, input result_t c);
    c_vld = v;
    c_in0 = a;
    c_in1 = b;
    c_in2 = c;
    step();
  endtask

  // skew=1: column k strobes k cycles after column 0; skew=0: all columns together.
  task automatic fill(input result_t v[9], input bit skew, input bit push);
    int      ncyc;
    int      r;
    result_t cin[3];
    logic [2:0] vl;
    if (push) begin
      for (int i = 0; i < 9; i++) sbq.push_back('{v[i], (i == 8), 1'b0, 4'd0, 4'd0});
    end
    ncyc = skew ? 5 : 3;
    for (int s = 0; s < ncyc; s++) begin
      if (s == ncyc - 1) chk("pre_send_valid", bus.o_valid, 0);
      vl = '0;
      for (int k = 0; k < 3; k++) begin
        cin[k] = '0;
        r = skew ? s - k : s;
        if (r >= 0 && r < 3) begin
          vl[k]  = 1'b1;
          cin[k] = v[r * 3 + k];
        end
      end
      drive(vl, cin[0], cin[1], cin[2]);
    end
    c_vld = '0;
    chk("send_latency", bus.o_valid, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (!in_ready && n < 300) begin
      step();
      n++;
    end
    chk("in_ready_back", in_ready, 1);
    chk("sb_empty", sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 0;
    end else begin
      if (stall_pend) begin
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_data", bus.o_data, held_d);
      end
      if (bus.o_valid && bus.o_ready) begin
        hs_cnt++;
        $display("xfer %0d data=%0d last=%0d", hs_cnt, bus.o_data, bus.o_last);
        if (sbq.size() == 0) begin
          chk("unexpected_output", bus.o_data, -1);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("data", bus.o_data, e.d);
          chk("last", bus.o_last, e.last);
`ifdef MATMUL_DRAIN_NORM_EN
          if (e.chk_norm) begin
            chk("norm", bus.o_norm, e.norm);
            chk("exp", bus.o_exp, e.ex);
          end
`endif
        end
      end
      stall_pend = bus.o_valid && !bus.o_ready;
      held_d     = bus.o_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    rst         = 1'b1;
    c_vld       = '0;
    c_in0       = '0;
    c_in1       = '0;
    c_in2       = '0;
    bus.o_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_last", bus.o_last, 0);
    chk("rst_o_data", bus.o_data, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef MATMUL_DRAIN_NORM_EN
    chk("rst_o_norm", bus.o_norm, 0);
    chk("rst_o_exp", bus.o_exp, 0);
`endif

    // Skewed capture, full throughput
    for (int i = 0; i < 9; i++) vals[i] = result_t'(i + 1);
    fill(vals, 1'b1, 1'b1);
    chk("in_ready_in_send", in_ready, 0);
    wait_idle(n);
    chk("drain_cycles", n, 9);

    // Backpressure with ready pattern 1,0,0
    hs0 = hs_cnt;
    fill(vals, 1'b1, 1'b1);
    bp_mode = 1;
    bp_ph   = 0;
    wait_idle(n);
    bp_mode     = 0;
    bus.o_ready = 1'b1;
    chk("bp_handshakes", hs_cnt - hs0, 9);

    // Simultaneous strobes, issued right after in_ready rises
    for (int i = 0; i < 9; i++) vals[i] = result_t'(i + 10);
    fill(vals, 1'b0, 1'b1);
    wait_idle(n);
    chk("simul_err", err, 0);

    // Overrun: 4th strobe on column 0, then a strobe during SEND
    for (int i = 0; i < 9; i++) sbq.push_back('{result_t'(40 + i), (i == 8), 1'b0, 4'd0, 4'd0});
    drive(3'b001, 40, 0, 0);
    drive(3'b001, 43, 0, 0);
    drive(3'b001, 46, 0, 0);
    chk("err_before_drop", err, 0);
    drive(3'b001, 99, 0, 0);
    chk("err_after_drop", err, 1);
    drive(3'b110, 0, 41, 42);
    drive(3'b110, 0, 44, 45);
    drive(3'b110, 0, 47, 48);
    chk("overrun_send", bus.o_valid, 1);
    chk("overrun_in_ready", in_ready, 0);
    drive(3'b111, 77, 77, 77);
    c_vld = '0;
    wait_idle(n);
    chk("err_sticky", err, 1);

    // Reset after 5 captures, then a fresh matrix
    drive(3'b111, 50, 51, 52);
    drive(3'b011, 53, 54, 0);
    c_vld = '0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_o_valid", bus.o_valid, 0);
    chk("midrst_err", err, 0);
    step();
    for (int i = 0; i < 9; i++) vals[i] = result_t'(i + 20);
    fill(vals, 1'b1, 1'b1);
    wait_idle(n);
    chk("post_rst_err", err, 0);

`ifdef MATMUL_DRAIN_NORM_EN
    // Normalization window, hand-derived for ACC_W=14, W=4
    vals = '{14'h00B4, 14'h0005, 14'h3000, 14'h0010, 14'h0800,
             14'h0000, 14'h000F, 14'h1000, 14'h07FF};
    sbq.push_back('{vals[0], 1'b0, 1'b1, 4'b1011, 4'd4});
    sbq.push_back('{vals[1], 1'b0, 1'b1, 4'b0101, 4'd0});
    sbq.push_back('{vals[2], 1'b0, 1'b1, 4'b1111, 4'd8});
    sbq.push_back('{vals[3], 1'b0, 1'b1, 4'b1000, 4'd1});
    sbq.push_back('{vals[4], 1'b0, 1'b1, 4'b1000, 4'd8});
    sbq.push_back('{vals[5], 1'b0, 1'b1, 4'b0000, 4'd0});
    sbq.push_back('{vals[6], 1'b0, 1'b1, 4'b1111, 4'd0});
    sbq.push_back('{vals[7], 1'b0, 1'b1, 4'b1111, 4'd8});
    sbq.push_back('{vals[8], 1'b1, 1'b1, 4'b1111, 4'd7});
    fill(vals, 1'b0, 1'b0);
    wait_idle(n);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matmul_result_drain.md
# matmul_result_drain

Output-side companion to the 3x3 systolic matrix multiplier. It captures the nine accumulated results as they leave the bottom edge of the PE array, one column stream per output column and skewed in time. It de-skews them into a 3x3 register file and transmits them serially, in row-major order, over a valid/ready stream to the downstream consumer. It replaces ad-hoc per-cycle tapping of PE sum outputs with a handshaked, order-guaranteed result path.

## Interface
Parameters:
- N, 5: operand width of the multiplier elements.
- ACC_W, 2*N+4: width of one accumulated result.
- DIM, 3: matrix dimension. Fixed at 3; other values are not supported.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- c_in0, c_in1, c_in2  input  ACC_W each  column result from the array's bottom edge.
- c_vld  input  3  per-column strobe; bit k qualifies c_ink for one cycle.
- in_ready  output  1  high when captures are accepted (IDLE or COLLECT).
- o_data  output  ACC_W  current result.
- o_valid  output  1  o_data valid.
- o_ready  input  1  consumer accepts.
- o_last  output  1  high with the 9th result (row 2, col 2).
- err  output  1  sticky drop flag; cleared only by rst.
- o_norm  output  N-1  normalized window. Present only with MATMUL_DRAIN_NORM_EN.
- o_exp  output  4  window shift. Present only with MATMUL_DRAIN_NORM_EN.

## Operation
- FSM states: IDLE, COLLECT, SEND.
- Each column k has a 2-bit row counter rc[k], 0..3.
- **IDLE → COLLECT:** the first cycle with any c_vld bit set. Data presented in that cycle is captured.
- **Capture:** when c_vld[k] is high and rc[k] < 3, store c_ink at mem[rc[k]][k] and increment rc[k]. All three columns capture independently in the same cycle.
- **Column-full drop:** c_vld[k] with rc[k] == 3 drops the data and sets err.
- **COLLECT → SEND:** on the cycle in which all rc reach 3, counting captures made in that same cycle.
- **SEND:**
  - o_valid is high and o_data = mem[idx/3][idx%3], with idx running 0..8.
  - idx advances on o_valid && o_ready.
  - o_last = (idx == 8).
  - The handshake on idx 8 returns the FSM to IDLE and clears idx and all rc.
- **Input during SEND:** in_ready is low. Any c_vld in SEND is dropped and sets err.
- **Output stability:** o_data and o_valid hold stable while o_valid && !o_ready.
- **Arithmetic:** none. Results pass through bit-exact.

## Timing
- All outputs are registered.
- Reset values: o_valid=0, o_last=0, o_data=0, err=0, in_ready=1, o_norm=0, o_exp=0. FSM goes to IDLE; rc, idx and mem are cleared.
- **rst mid-operation:** the partial matrix is discarded, no further output is emitted, and the block is in IDLE on the next cycle.
- **Latency:** if the final capture occurs in cycle t, o_valid is high from cycle t+1.
- **Throughput:** with o_ready held high, 9 results stream on 9 consecutive cycles. in_ready rises the cycle after the last handshake.
- **Back-to-back matrices:** a new c_vld may arrive in the cycle after in_ready rises.

## Configuration
- Macro: MATMUL_DRAIN_NORM_EN.
- **Defined:** o_norm and o_exp are added and are registered alongside o_data. Normalization of v = o_data, with W = N-1:
  - If any bit above ACC_W-3 is set, o_norm is all ones and o_exp = ACC_W-2-W.
  - Otherwise find the highest set bit j in [ACC_W-3 .. W]; o_norm = v[j : j-W+1] and o_exp = j-W+1.
  - If no such bit is set, o_norm = v[W-1:0] and o_exp = 0.
- **Undefined:** neither port exists and no normalization logic is built.

## Structure
- Package matmul_pkg holds:
  - N, ACC_W, DIM;
  - the state enum (IDLE, COLLECT, SEND);
  - the result typedef (logic [ACC_W-1:0]).
- Sub-module lead_one_norm: a combinational leading-one window extractor. It is instantiated only under MATMUL_DRAIN_NORM_EN.

## Test plan
- **Skewed capture:**
  - Stimulus: column 0 strobes in cycles 1-3, column 1 in cycles 2-4, column 2 in cycles 3-5; values 1..9, row-major. o_ready=1.
  - Response: o_valid from cycle 6; o_data 1,2,…,9 on consecutive cycles; o_last only with 9.
- **Backpressure:**
  - Stimulus: same fill; o_ready toggles 1,0,0,1,…
  - Response: each value holds stable while stalled; exactly 9 handshakes; order unchanged.
- **Simultaneous strobes:**
  - Stimulus: c_vld=3'b111 for 3 cycles, values 10..18.
  - Response: SEND entered the cycle after the third strobe; output 10..18.
- **Overrun:**
  - Stimulus: a 4th strobe on column 0 before the matrix completes, then a strobe during SEND.
  - Response: err=1 after the first drop; the stream still outputs the original 9 values.
- **Reset mid-operation:**
  - Stimulus: assert rst after 5 captures, then run a fresh fill of 20..28.
  - Response: only 20..28 emerge; err=0.
- **NORM_EN:**
  - Stimulus: result 0x0B4 (bit 7 highest), N=5.
  - Response: o_norm=4'b1011, o_exp=4.
  - Stimulus: result 0x005.
  - Response: o_norm=4'b0101, o_exp=0.
